// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared constants for the HI/LO multiply/divide unit:
//               operation encodings, FSM state encodings, default operand
//               width and iteration count.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int ITER_COUNT = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIX  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_if
// Description : Operand / control / result bundle between the EX stage and
//               the multiply/divide unit.
//   start, op, a, b      : launch request and operands
//   mthi, mtlo, wdata    : direct HI/LO writes
//   busy, done, div0     : status (registered)
//   hi, lo               : HI/LO register contents
//   modport master : EX-stage side, slave : hilo_muldiv side
// Revision    : 1.0 - initial release
// ============================================================================
interface hilo_muldiv_if #(
  parameter int WIDTH = muldiv_pkg::WIDTH_DEF
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, div0, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_signfix
// Description : Combinational sign correction of the unsigned iteration
//               results and HI/LO selection.
//   i_is_div : 1 = divide result (quotient/remainder), 0 = product
//   i_neg_q  : negate product (multiply) or quotient (divide)
//   i_neg_r  : negate remainder (divide only)
//   i_prod   : unsigned 2*WIDTH product
//   i_quo    : unsigned quotient
//   i_rem    : unsigned remainder
//   o_hi     : value for HI
//   o_lo     : value for LO
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  wire logic               i_is_div,
  input  wire logic               i_neg_q,
  input  wire logic               i_neg_r,
  input  wire logic [2*WIDTH-1:0] i_prod,
  input  wire logic [WIDTH-1:0]   i_quo,
  input  wire logic [WIDTH-1:0]   i_rem,
  output logic      [WIDTH-1:0]   o_hi,
  output logic      [WIDTH-1:0]   o_lo
);

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  always_comb begin
    w_prod = i_neg_q ? -i_prod : i_prod;
    w_quo  = i_neg_q ? -i_quo  : i_quo;
    w_rem  = i_neg_r ? -i_rem  : i_rem;
    if (i_is_div) begin
      o_hi = w_rem;
      o_lo = w_quo;
    end else begin
      o_hi = w_prod[2*WIDTH-1:WIDTH];
      o_lo = w_prod[WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv
// Description : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
//               One iteration per cycle for WIDTH cycles, then one cycle of
//               sign correction and commit; fixed 33-cycle latency at
//               WIDTH=32.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : hilo_muldiv_if.slave (start/op/a/b, mthi/mtlo/wdata,
//           busy/done/div0, hi/lo)
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input wire logic     clk,
  input wire logic     reset,
  hilo_muldiv_if.slave bus
);

  // One iteration per operand bit.
  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_b_zero;
  logic [WIDTH-1:0]   r_mag_a;   // multiplicand magnitude
  logic [WIDTH-1:0]   r_mag_b;   // divisor magnitude
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide  : low half shifts dividend out and quotient in; high half idle.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_div0;

  logic               w_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // Launch-time operand conditioning (MULT and DIV are the signed ops).
  always_comb begin
    w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    w_abs_a  = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    w_abs_b  = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // Iteration datapath.
  always_comb begin
    // Shift-add: add multiplicand when the current multiplier LSB is set,
    // then shift the whole accumulator right keeping the carry.
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
               + (r_acc[0] ? {1'b0, r_mag_a} : {(WIDTH+1){1'b0}});
    w_mul_next = {w_sum, r_acc[WIDTH-1:1]};
    // Restoring divide: the true difference always fits WIDTH bits when
    // it is kept, so a WIDTH-bit subtract is sufficient.
    w_shift    = {r_rem, r_acc[WIDTH-1]};
    w_ge       = (w_shift >= {1'b0, r_mag_b});
    w_diff     = w_shift[WIDTH-1:0] - r_mag_b;
  end

  muldiv_signfix #(
    .WIDTH (WIDTH)
  ) u_signfix (
    .i_is_div (r_is_div),
    .i_neg_q  (r_neg_q),
    .i_neg_r  (r_neg_r),
    .i_prod   (r_acc),
    .i_quo    (r_acc[WIDTH-1:0]),
    .i_rem    (r_rem),
    .o_hi     (w_fix_hi),
    .o_lo     (w_fix_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state  <= ST_RUN;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_is_div <= bus.op[1];
            r_neg_q  <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r  <= (bus.op == OP_DIV) && bus.a[WIDTH-1];
            r_b_zero <= (bus.b == '0);
            r_mag_a  <= w_abs_a;
            r_mag_b  <= w_abs_b;
            r_rem    <= '0;
            r_acc    <= bus.op[1] ? {{WIDTH{1'b0}}, w_abs_a}
                                  : {{WIDTH{1'b0}}, w_abs_b};
          end else begin
            if (bus.mthi) r_hi <= bus.wdata;
            if (bus.mtlo) r_lo <= bus.wdata;
          end
        end
        ST_RUN: begin
          if (r_is_div) begin
            r_rem              <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= w_mul_next;
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= ST_FIX;
        end
        ST_FIX: begin
          // Divide by zero: the iteration leaves |a| as remainder, which
          // the sign fix turns back into a as supplied; only LO needs an
          // override since the quotient sign fix would corrupt all-ones.
          r_hi    <= w_fix_hi;
          r_lo    <= (r_is_div && r_b_zero) ? {WIDTH{1'b1}} : w_fix_lo;
          r_div0  <= r_is_div && r_b_zero;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.div0 = r_div0;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: doc/hilo_muldiv.md
# hilo_muldiv

Iterative multiply/divide unit with its own HI/LO register pair, sitting in the EX stage beside the ALU and consuming the same A/B operand buses. It executes MULT, MULTU, DIV and DIVU over multiple cycles while the pipeline stalls on `busy`. It then holds the 64-bit result in HI/LO for MFHI/MFLO, which read `hi`/`lo` through the EX result mux downstream of the ALU. The ALU keeps all single-cycle operations; this block owns everything that writes HI/LO.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: launch request; sampled only in IDLE.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` input WIDTH: multiplicand or dividend (rs).
- `b` input WIDTH: multiplier or divisor (rt).
- `mthi` input 1: write `wdata` to HI; accepted only in IDLE.
- `mtlo` input 1: write `wdata` to LO; accepted only in IDLE.
- `wdata` input WIDTH: MTHI/MTLO data.
- `busy` output 1: operation in progress; pipeline stall request.
- `done` output 1: one-cycle pulse when HI/LO have just been written by an operation.
- `div0` output 1: valid with `done`; high when a DIV or DIVU had `b`==0.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: performs 32 iterations.
  - FIX: applies sign correction and commits the result.
- IDLE→RUN when `start`=1. On that edge:
  - latch `op`;
  - latch |a| and |b| (magnitudes for signed ops, raw values for unsigned);
  - latch result-sign flags;
  - clear the iteration counter.
- RUN, one iteration per cycle:
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract on a 33-bit partial remainder.
  - Counter runs 0..31; RUN→FIX on the edge where counter=31.
- FIX→IDLE on the next edge. That edge:
  - writes HI/LO;
  - sets `done`=1 for that one cycle;
  - sets `div0` as computed.
- Multiply result:
  - HI:LO = 64-bit product.
  - For MULT, the product is negated when the sign bits of `a` and `b` differ.
- Divide result:
  - LO = quotient, HI = remainder.
  - For DIV, the quotient is negated when the signs differ; the remainder takes the sign of the dividend.
  - DIV of 0x8000_0000 by 0xFFFF_FFFF gives LO=0x8000_0000, HI=0, `div0`=0.
- Divide by zero (DIV or DIVU): LO=0xFFFF_FFFF, HI=`a` as supplied, `div0`=1. Full latency still applies.
- MTHI/MTLO in IDLE with `start`=0: the selected register takes `wdata` on the edge. If both are asserted, both registers are written.
- `start` together with `mthi`/`mtlo` in IDLE: `start` wins; the moves are dropped.
- `start`, `mthi` and `mtlo` are ignored while in RUN or FIX.
- `op`, `a` and `b` may change freely after the launch edge.

## Timing
- Reset values:
  - `hi`=0, `lo`=0;
  - `busy`=0, `done`=0, `div0`=0;
  - state IDLE, counter 0.
- Reset in RUN or FIX aborts the operation and applies all reset values on that edge.
- Launch edge E0:
  - `busy`=1 from E0 through E33 (high for 33 cycles).
  - E1..E32 are RUN iterations.
  - E33 is the FIX commit: `hi`/`lo` are updated, `done`=1 and `busy`=0 in the same cycle after E33.
- Latency: 33 cycles from launch to valid `hi`/`lo`, fixed for every op and operand.
- Throughput: `start` is accepted in the cycle after E33. Back-to-back operations are spaced 34 edges apart.
- `hi`/`lo` hold their previous values throughout RUN; there are no partial-result glitches.
- `busy` and `done` are registered outputs; no combinational path from inputs.

## Structure
- Package `muldiv_pkg`:
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`;
  - FSM state enum;
  - `WIDTH` default;
  - iteration count constant 32.
- Sub-module `muldiv_signfix`: combinational sign-correction block. It negates the product, quotient and remainder per the sign flags, and is instantiated once in FIX.
- Top level holds the FSM, the counter, the iteration datapath and the HI/LO registers.

## Test plan
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF → after E33: HI=0xFFFF_FFFE, LO=0x0000_0001; `busy` high for exactly 33 cycles; `done` is a single pulse.
- MULT a=-3, b=7 → HI=0xFFFF_FFFF, LO=0xFFFF_FFEB. DIV a=-7, b=2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- DIVU a=100, b=0 → LO=0xFFFF_FFFF, HI=0x0000_0064, `div0`=1 with `done`. DIV 0x8000_0000 / -1 → LO=0x8000_0000, HI=0.
- `start` and `mthi` (`wdata`=0x1234) asserted at cycle 10 of a running MULTU 5×6 → both ignored; result is HI=0, LO=30. MTHI 0x1234 in IDLE → HI=0x1234, LO unchanged.
- `reset` asserted at cycle 15 of DIVU 1000/7 → next cycle shows `hi`=`lo`=0, `busy`=0 and no `done`. A new DIVU 1000/7 then yields LO=142, HI=6.
